// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared word, fetch-entry and fetch FSM types
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t instr;
        word_t pcn;
    } fetch_entry_t;

    typedef enum logic {
        FQ_RUN     = 1'b0,
        FQ_HALTED  = 1'b1
    } fq_state_t;

    localparam word_t WORD_BYTES = 32'd4;

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - icache, redirect and decode signals of fetch_queue
interface fetch_queue_if #(
    parameter int DEPTH = 4
) ();
    import cpu_types_pkg::*;

    logic                     ihit;
    word_t                    imemload;
    logic                     imemREN;
    word_t                    imemaddr;
    logic                     redirect;
    word_t                    redirect_addr;
    logic                     halt;
    logic                     deq;
    logic                     instr_valid;
    word_t                    instr;
    word_t                    pcn;
    logic [$clog2(DEPTH):0]   count;

    // master: the environment (icache, branch unit, decode)
    modport master (
        output ihit, imemload, redirect, redirect_addr, halt, deq,
        input  imemREN, imemaddr, instr_valid, instr, pcn, count
    );

    // slave: the fetch queue itself
    modport slave (
        input  ihit, imemload, redirect, redirect_addr, halt, deq,
        output imemREN, imemaddr, instr_valid, instr, pcn, count
    );

endinterface

// File: rtl/fq_buffer.sv
// rtl/fq_buffer.sv - circular entry storage with read/write pointers and count
module fq_buffer
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    flush,
    input  logic                    wr_en,
    input  fetch_entry_t            wdata,
    input  logic                    rd_en,
    output fetch_entry_t            head,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
            if (wr_en && !rd_en) count_d = count_q + 1'b1;
            else if (!wr_en && rd_en) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
    end

    // Storage is never cleared; count alone decides what is visible.
    always_ff @(posedge clk) begin
        if (!flush && wr_en) mem_q[wr_ptr_q] <= wdata;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch PC, RUN/HALTED FSM and queue to decode
// Optional empty-queue bypass selected by macro FETCH_QUEUE_BYPASS_EN.
module fetch_queue
    import cpu_types_pkg::*;
#(
    parameter int    DEPTH   = 4,
    parameter word_t PC_INIT = 32'h0
) (
    input  logic          CLK,
    input  logic          RST,
    fetch_queue_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fq_state_t          state_q, state_d;
    word_t              pc_q, pc_d;
    logic [CNT_W-1:0]   count;
    fetch_entry_t       head;
    fetch_entry_t       in_entry;
    logic               empty;
    logic               fetch_ok;
    logic               enq;
    logic               bypass;
    logic               wr_en;
    logic               rd_en;
    logic               flush;

    fq_buffer #(.DEPTH(DEPTH)) u_buffer (
        .clk   (CLK),
        .flush (flush),
        .wr_en (wr_en),
        .wdata (in_entry),
        .rd_en (rd_en),
        .head  (head),
        .count (count)
    );

    always_comb begin
        empty    = (count == '0);
        fetch_ok = !RST && (state_q == FQ_RUN) && !bus.redirect
                   && ((count < DEPTH_C) || bus.deq);
        enq      = fetch_ok && bus.ihit;
        in_entry = '{instr: bus.imemload, pcn: pc_q + WORD_BYTES};
`ifdef FETCH_QUEUE_BYPASS_EN
        // enq is already false under RST or redirect, which suppresses bypass
        bypass   = empty && enq;
`else
        bypass   = 1'b0;
`endif
        wr_en    = enq && !(bypass && bus.deq);
        rd_en    = bus.deq && !empty;
        flush    = RST || bus.redirect;
    end

    always_comb begin
        bus.imemREN     = fetch_ok;
        bus.imemaddr    = pc_q;
        bus.count       = count;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.pcn         = '0;
        if (!empty) begin
            bus.instr_valid = 1'b1;
            bus.instr       = head.instr;
            bus.pcn         = head.pcn;
        end else if (bypass) begin
            bus.instr_valid = 1'b1;
            bus.instr       = in_entry.instr;
            bus.pcn         = in_entry.pcn;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (bus.redirect) begin
            state_d = FQ_RUN;
            pc_d    = bus.redirect_addr;
        end else begin
            if (state_q == FQ_RUN && bus.halt) state_d = FQ_HALTED;
            if (enq) pc_d = pc_q + WORD_BYTES;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= FQ_RUN;
            pc_q    <= PC_INIT;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;
    import cpu_types_pkg::*;

`ifdef FETCH_QUEUE_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic  clk = 1'b0;
    logic  rst;
    logic  force_word;
    word_t word_val;
    int    checks = 0;
    int    passed = 0;

    fetch_queue_if #(.DEPTH(4)) fq ();

    fetch_queue #(.DEPTH(4), .PC_INIT(32'h0)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (fq.slave)
    );

    always #5 clk = ~clk;

    // Fetched word encodes its own address so stale words are recognisable.
    assign fq.imemload = force_word ? word_val : (32'hA000_0000 | fq.imemaddr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        force_word = 1'b0;
        word_val = '0;
        fq.ihit = 1'b0;
        fq.redirect = 1'b0;
        fq.redirect_addr = '0;
        fq.halt = 1'b0;
        fq.deq = 1'b0;

        // reset state
        tick();
        fq.ihit = 1'b1;
        #1;
        check("rst_ren", 32'(fq.imemREN), 32'd0);
        tick();
        check("rst_count", 32'(fq.count), 32'd0);
        check("rst_valid", 32'(fq.instr_valid), 32'd0);
        check("rst_instr", fq.instr, 32'h0);
        check("rst_pcn", fq.pcn, 32'h0);
        check("rst_addr", fq.imemaddr, 32'h0);

        // streaming
        rst = 1'b0;
        #1;
        check("s0_ren", 32'(fq.imemREN), 32'd1);
        check("s0_valid", 32'(fq.instr_valid), 32'(BYP));
        tick();
        fq.deq = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            #1;
            check("s_valid", 32'(fq.instr_valid), 32'd1);
            check("s_pcn", fq.pcn, 32'(4 * k));
            check("s_instr", fq.instr, 32'hA000_0000 | 32'(4 * (k - 1)));
            check("s_addr", fq.imemaddr, 32'(4 * k));
            check("s_count", 32'(fq.count), 32'd1);
            tick();
        end
        rst = 1'b1;
        fq.ihit = 1'b0;
        fq.deq = 1'b0;
        tick();
        rst = 1'b0;

        // fill to full
        fq.ihit = 1'b1;
        for (int n = 0; n < 4; n++) begin
            #1;
            check("f_count", 32'(fq.count), 32'(n));
            check("f_ren", 32'(fq.imemREN), 32'd1);
            tick();
        end
        check("full_count", 32'(fq.count), 32'd4);
        check("full_ren", 32'(fq.imemREN), 32'd0);
        check("full_pcn", fq.pcn, 32'h4);
        check("full_addr", fq.imemaddr, 32'h10);
        fq.deq = 1'b1;
        #1;
        check("full_deq_ren", 32'(fq.imemREN), 32'd1);
        tick();
        check("fd_count", 32'(fq.count), 32'd4);
        check("fd_pcn", fq.pcn, 32'h8);
        check("fd_instr", fq.instr, 32'hA000_0004);
        check("fd_addr", fq.imemaddr, 32'h14);

        // reset over a full queue beats redirect/halt/ihit/deq
        rst = 1'b1;
        fq.redirect = 1'b1;
        fq.redirect_addr = 32'h200;
        fq.halt = 1'b1;
        #1;
        check("rm_ren", 32'(fq.imemREN), 32'd0);
        tick();
        check("rm_count", 32'(fq.count), 32'd0);
        check("rm_valid", 32'(fq.instr_valid), 32'd0);
        check("rm_addr", fq.imemaddr, 32'h0);
        rst = 1'b0;
        fq.redirect = 1'b0;
        fq.halt = 1'b0;
        fq.deq = 1'b0;

        // redirect with 3 queued entries, ihit discarded
        tick();
        tick();
        tick();
        check("r3_count", 32'(fq.count), 32'd3);
        check("r3_addr", fq.imemaddr, 32'hC);
        fq.redirect = 1'b1;
        fq.redirect_addr = 32'h100;
        force_word = 1'b1;
        word_val = 32'hDEAD_BEEF;
        #1;
        check("r_ren", 32'(fq.imemREN), 32'd0);
        tick();
        check("r_count", 32'(fq.count), 32'd0);
        check("r_addr", fq.imemaddr, 32'h100);
        check("r_valid", 32'(fq.instr_valid), 32'd0);
        fq.redirect = 1'b0;
        force_word = 1'b0;
        tick();
        check("r1_count", 32'(fq.count), 32'd1);
        check("r1_instr", fq.instr, 32'hA000_0100);
        check("r1_pcn", fq.pcn, 32'h104);

        // halt, drain, redirect wins over halt
        tick();
        check("h_count", 32'(fq.count), 32'd2);
        check("h_addr", fq.imemaddr, 32'h108);
        fq.ihit = 1'b0;
        fq.halt = 1'b1;
        tick();
        fq.halt = 1'b0;
        fq.ihit = 1'b1;
        #1;
        check("hl_ren", 32'(fq.imemREN), 32'd0);
        check("hl_count", 32'(fq.count), 32'd2);
        check("hl_pcn", fq.pcn, 32'h104);
        fq.deq = 1'b1;
        tick();
        check("hd1_count", 32'(fq.count), 32'd1);
        check("hd1_pcn", fq.pcn, 32'h108);
        check("hd1_ren", 32'(fq.imemREN), 32'd0);
        tick();
        check("hd2_count", 32'(fq.count), 32'd0);
        check("hd2_valid", 32'(fq.instr_valid), 32'd0);
        tick();
        check("he_count", 32'(fq.count), 32'd0);
        check("he_addr", fq.imemaddr, 32'h108);
        fq.deq = 1'b0;
        fq.redirect = 1'b1;
        fq.halt = 1'b1;
        fq.redirect_addr = 32'h40;
        tick();
        check("hr_addr", fq.imemaddr, 32'h40);
        fq.redirect = 1'b0;
        fq.halt = 1'b0;
        #1;
        check("hr_ren", 32'(fq.imemREN), 32'd1);
        tick();
        check("hr_count", 32'(fq.count), 32'd1);
        check("hr_pcn", fq.pcn, 32'h44);
        check("hr_addr2", fq.imemaddr, 32'h44);

        // bypass / first-entry latency
        rst = 1'b1;
        fq.ihit = 1'b0;
        tick();
        rst = 1'b0;
        fq.ihit = 1'b1;
        force_word = 1'b1;
        word_val = 32'h2001_000A;
        #1;
        check("b_valid", 32'(fq.instr_valid), 32'(BYP));
        check("b_instr", fq.instr, BYP ? 32'h2001_000A : 32'h0);
        tick();
        fq.ihit = 1'b0;
        check("b1_valid", 32'(fq.instr_valid), 32'd1);
        check("b1_instr", fq.instr, 32'h2001_000A);
        check("b1_count", 32'(fq.count), 32'd1);

        // PC wrap
        fq.redirect = 1'b1;
        fq.redirect_addr = 32'hFFFF_FFFC;
        force_word = 1'b0;
        tick();
        fq.redirect = 1'b0;
        fq.ihit = 1'b1;
        #1;
        check("w_addr0", fq.imemaddr, 32'hFFFF_FFFC);
        tick();
        check("w_addr", fq.imemaddr, 32'h0);
        check("w_pcn", fq.pcn, 32'h0);
        check("w_instr", fq.instr, 32'hFFFF_FFFC);
        check("w_count", 32'(fq.count), 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
